// File: rtl/connect4_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// connect4_game_ctrl_if
//
// Bundles the button inputs and the display-facing outputs of the Connect-4
// game controller.
//
// Button semantics: btn_left / btn_right / btn_drop / btn_start are
// single-cycle, debounced pulses. The controller samples them on the rising
// clock edge and acts on a pulse only in the state where that button means
// something. There is no back-pressure: a pulse that arrives in a state that
// ignores it is lost.
//
// Signals
//   btn_left, btn_right, btn_drop, btn_start : button pulses (master -> slave)
//   board        [41:0] : occupancy, bit 7*row+col, row 0 bottom, col 0 left
//   colors       [41:0] : chip colour per cell, 1 = black, 0 = red
//   selected_col [2:0]  : column of the hovering chip, 0..6
//   player              : current turn, 1 = black, 0 = red
//   game_over           : high while the game has ended
//   winner       [1:0]  : 00 draw, 01 red, 10 black (valid with game_over)
//   start_state         : high while waiting for a game to start
//   end_state           : high while the game has ended
//   state_dbg    [2:0]  : current controller state, for observation only
//
// Modports
//   master : button source / observer side
//   slave  : the game controller
// -----------------------------------------------------------------------------
interface connect4_game_ctrl_if;
    logic        btn_left;
    logic        btn_right;
    logic        btn_drop;
    logic        btn_start;
    logic [41:0] board;
    logic [41:0] colors;
    logic [2:0]  selected_col;
    logic        player;
    logic        game_over;
    logic [1:0]  winner;
    logic        start_state;
    logic        end_state;
    logic [2:0]  state_dbg;

    modport master (
        output btn_left, btn_right, btn_drop, btn_start,
        input  board, colors, selected_col, player, game_over, winner,
        input  start_state, end_state, state_dbg
    );

    modport slave (
        input  btn_left, btn_right, btn_drop, btn_start,
        output board, colors, selected_col, player, game_over, winner,
        output start_state, end_state, state_dbg
    );
endinterface

// File: rtl/connect4_game_ctrl.sv
// -----------------------------------------------------------------------------
// connect4_game_ctrl
//
// Connect-4 game controller. Owns the 6x7 board and chip colours, the
// selected column, whose turn it is, and the win/draw result. Sequences
// INIT -> PLAY -> DROP -> CHK_H -> CHK_V -> CHK_D1 -> CHK_D2 -> PLAY/END.
// A drop scans the chosen column bottom-up one row per cycle; the four win
// directions are then checked one per cycle around the chip just placed.
//
// Ports
//   Clk   : system clock, all state changes on the rising edge
//   Reset : synchronous, active-high reset
//   bus   : connect4_game_ctrl_if.slave (buttons in, display state out)
//
// Parameters
//   START_COL    : column selected at reset and at every new game (0..6)
//   FIRST_PLAYER : player to move first (0 = red, 1 = black)
// -----------------------------------------------------------------------------
module connect4_game_ctrl #(
    parameter int   START_COL    = 3,
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    connect4_game_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        PLAY   = 3'd1,
        DROP   = 3'd2,
        CHK_H  = 3'd3,
        CHK_V  = 3'd4,
        CHK_D1 = 3'd5,
        CHK_D2 = 3'd6,
        END    = 3'd7
    } state_t;

    localparam logic [2:0] START_COL_L = 3'(START_COL);

    state_t      state_q, state_d;
    logic [41:0] board_q, board_d;
    logic [41:0] colors_q, colors_d;
    logic [2:0]  sel_q, sel_d;
    logic        player_q, player_d;
    logic [1:0]  winner_q, winner_d;
    logic        game_over_q, game_over_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
    logic [5:0]  move_cnt_q, move_cnt_d;
    logic [2:0]  scan_q, scan_d;
    logic [2:0]  last_row_q, last_row_d;
    logic [2:0]  last_col_q, last_col_d;
    logic        win_flag_q, win_flag_d;

    int          dir_r, dir_c;
    logic        line_hit;
    logic [5:0]  top_idx;
    logic [5:0]  cell_idx;

    // Counts same-colour chips contiguous with (row, col) along +/-(dr, dc),
    // at most three each way, stopping at the board edge or the first gap or
    // foreign chip. Returns 1 when the line including (row, col) reaches 4.
    function automatic logic line_win(
        input logic [41:0] b,
        input logic [41:0] c,
        input logic [2:0]  row,
        input logic [2:0]  col,
        input logic        pc,
        input int          dr,
        input int          dc
    );
        int         cnt;
        int         rp, cp, rn, cn;
        logic       run_pos, run_neg;
        logic [5:0] ip, in_;
        cnt     = 1;
        run_pos = 1'b1;
        run_neg = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rp  = int'(row) + k * dr;
            cp  = int'(col) + k * dc;
            rn  = int'(row) - k * dr;
            cn  = int'(col) - k * dc;
            ip  = 6'(7 * rp + cp);
            in_ = 6'(7 * rn + cn);
            if (run_pos && rp >= 0 && rp <= 5 && cp >= 0 && cp <= 6 &&
                b[ip] && (c[ip] == pc))
                cnt++;
            else
                run_pos = 1'b0;
            if (run_neg && rn >= 0 && rn <= 5 && cn >= 0 && cn <= 6 &&
                b[in_] && (c[in_] == pc))
                cnt++;
            else
                run_neg = 1'b0;
        end
        return (cnt >= 4);
    endfunction

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        colors_d   = colors_q;
        sel_d      = sel_q;
        player_d   = player_q;
        winner_d   = winner_q;
        move_cnt_d = move_cnt_q;
        scan_d     = scan_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        win_flag_d = win_flag_q;
        dir_r      = 0;
        dir_c      = 0;

        top_idx  = 6'd35 + {3'b000, sel_q};
        cell_idx = 6'(scan_q) * 6'd7 + {3'b000, sel_q};

        // Direction examined by the current check state. CHK_D2 runs
        // up-left, expressed as (+1, -1).
        case (state_q)
            CHK_H:   begin dir_r = 0; dir_c = 1;  end
            CHK_V:   begin dir_r = 1; dir_c = 0;  end
            CHK_D1:  begin dir_r = 1; dir_c = 1;  end
            CHK_D2:  begin dir_r = 1; dir_c = -1; end
            default: begin dir_r = 0; dir_c = 0;  end
        endcase
        line_hit = line_win(board_q, colors_q, last_row_q, last_col_q,
                            player_q, dir_r, dir_c);

        case (state_q)
            INIT: begin
                if (bus.btn_start)
                    state_d = PLAY;
            end

            PLAY: begin
                if (bus.btn_drop) begin
                    // Drop wins over movement; a full column swallows it.
                    if (!board_q[top_idx]) begin
                        state_d    = DROP;
                        scan_d     = 3'd0;
                        win_flag_d = 1'b0;
                    end
                end else if (bus.btn_left && bus.btn_right) begin
                    sel_d = sel_q;
                end else if (bus.btn_left) begin
                    if (sel_q != 3'd0)
                        sel_d = sel_q - 3'd1;
                end else if (bus.btn_right) begin
                    if (sel_q != 3'd6)
                        sel_d = sel_q + 3'd1;
                end
            end

            DROP: begin
                if (!board_q[cell_idx]) begin
                    board_d[cell_idx]  = 1'b1;
                    colors_d[cell_idx] = player_q;
                    last_row_d         = scan_q;
                    last_col_d         = sel_q;
                    move_cnt_d         = move_cnt_q + 6'd1;
                    state_d            = CHK_H;
                end else begin
                    scan_d = scan_q + 3'd1;
                end
            end

            CHK_H: begin
                if (line_hit) win_flag_d = 1'b1;
                state_d = CHK_V;
            end

            CHK_V: begin
                if (line_hit) win_flag_d = 1'b1;
                state_d = CHK_D1;
            end

            CHK_D1: begin
                if (line_hit) win_flag_d = 1'b1;
                state_d = CHK_D2;
            end

            CHK_D2: begin
                // Last direction is folded in directly so the decision
                // does not need an extra cycle.
                if (win_flag_q || line_hit) begin
                    win_flag_d = 1'b1;
                    winner_d   = player_q ? 2'b10 : 2'b01;
                    state_d    = END;
                end else if (move_cnt_q == 6'd42) begin
                    winner_d = 2'b00;
                    state_d  = END;
                end else begin
                    player_d = ~player_q;
                    state_d  = PLAY;
                end
            end

            END: begin
                if (bus.btn_start) begin
                    state_d    = INIT;
                    board_d    = '0;
                    colors_d   = '0;
                    player_d   = FIRST_PLAYER;
                    sel_d      = START_COL_L;
                    winner_d   = 2'b00;
                    move_cnt_d = 6'd0;
                    win_flag_d = 1'b0;
                end
            end

            default: state_d = INIT;
        endcase

        game_over_d = (state_d == END);
        end_d       = (state_d == END);
        start_d     = (state_d == INIT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= INIT;
            board_q     <= '0;
            colors_q    <= '0;
            sel_q       <= START_COL_L;
            player_q    <= FIRST_PLAYER;
            winner_q    <= 2'b00;
            game_over_q <= 1'b0;
            start_q     <= 1'b1;
            end_q       <= 1'b0;
            move_cnt_q  <= 6'd0;
            scan_q      <= 3'd0;
            last_row_q  <= 3'd0;
            last_col_q  <= 3'd0;
            win_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            colors_q    <= colors_d;
            sel_q       <= sel_d;
            player_q    <= player_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            start_q     <= start_d;
            end_q       <= end_d;
            move_cnt_q  <= move_cnt_d;
            scan_q      <= scan_d;
            last_row_q  <= last_row_d;
            last_col_q  <= last_col_d;
            win_flag_q  <= win_flag_d;
        end
    end

    assign bus.board        = board_q;
    assign bus.colors       = colors_q;
    assign bus.selected_col = sel_q;
    assign bus.player       = player_q;
    assign bus.winner       = winner_q;
    assign bus.game_over    = game_over_q;
    assign bus.start_state  = start_q;
    assign bus.end_state    = end_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_connect4_game_ctrl.sv
module tb_connect4_game_ctrl;

    localparam int W = 96;

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_DROP = 3'd2;
    localparam logic [2:0] S_CHKH = 3'd3;
    localparam logic [2:0] S_END  = 3'd7;

    logic Clk = 1'b0;
    logic Reset;

    connect4_game_ctrl_if bus();

    connect4_game_ctrl #(
        .START_COL    (3),
        .FIRST_PLAYER (1'b0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         chk_req = 1'b0;

    // ---------------- reference model state ----------------
    logic [41:0] m_board, m_colors;
    int          m_sel;
    logic        m_player;
    logic [1:0]  m_winner;
    logic [2:0]  m_state;
    int          height[7];

    function automatic logic [W-1:0] pack_exp();
        logic is_end, is_init;
        is_end  = (m_state == S_END);
        is_init = (m_state == S_INIT);
        return {m_board, m_colors, 3'(m_sel), m_player, is_end, m_winner,
                is_init, is_end, m_state};
    endfunction

    task automatic m_reset();
        m_board  = '0;
        m_colors = '0;
        m_sel    = 3;
        m_player = 1'b0;
        m_winner = 2'b00;
        m_state  = S_INIT;
        for (int i = 0; i < 7; i++) height[i] = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        logic [W-1:0] act, e;
        string        n;
        if (chk_req) begin
            act = {bus.board, bus.colors, bus.selected_col, bus.player,
                   bus.game_over, bus.winner, bus.start_state, bus.end_state,
                   bus.state_dbg};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor_underflow: got %h, required a queued expectation", act);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", n, act, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
        chk_req = 1'b0;
    endtask

    // At most one expectation per cycle; the monitor takes it at the next negedge.
    task automatic expect_now(input string n);
        exp_q.push_back(pack_exp());
        name_q.push_back(n);
        chk_req = 1'b1;
    endtask

    task automatic press(input bit l, input bit r, input bit d, input bit s);
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_drop  = d;
        bus.btn_start = s;
        step();
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_drop  = 1'b0;
        bus.btn_start = 1'b0;
    endtask

    task automatic press_sel(input bit l, input bit r);
        press(l, r, 1'b0, 1'b0);
        if (l && r) ;
        else if (l && m_sel > 0) m_sel--;
        else if (r && m_sel < 6) m_sel++;
    endtask

    task automatic move_to(input int col);
        while (m_sel < col) press_sel(1'b0, 1'b1);
        while (m_sel > col) press_sel(1'b1, 1'b0);
    endtask

    // PLAY (or END) is reached r+6 cycles after the drop cycle for row r.
    task automatic do_drop(input int col, input bit ends, input logic [1:0] win,
                           input string n);
        int r;
        move_to(col);
        r = height[col];
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (r + 5) step();
        m_board[7*r+col]  = 1'b1;
        m_colors[7*r+col] = m_player;
        height[col]++;
        if (ends) begin
            m_state  = S_END;
            m_winner = win;
        end else begin
            m_player = ~m_player;
            m_state  = S_PLAY;
        end
        expect_now(n);
    endtask

    task automatic reset_and_start();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        m_reset();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_state = S_PLAY;
    endtask

    // ---------------- stimulus tables ----------------
    int vert_cols[7]  = '{0, 1, 0, 1, 0, 1, 0};
    int diag_cols[12] = '{2, 1, 3, 2, 4, 6, 3, 3, 4, 0, 4, 4};
    // (column, count) runs: columns 0,1,4,5 end up red-bottom, 2,3,6
    // black-bottom, which leaves no line of four anywhere.
    int draw_col[10]  = '{0, 1, 2, 1, 4, 3, 4, 5, 6, 5};
    int draw_cnt[10]  = '{6, 1, 6, 5, 1, 6, 5, 1, 6, 5};

    initial begin
        int k;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_drop  = 1'b0;
        bus.btn_start = 1'b0;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        m_reset();
        expect_now("reset_values");

        // start and idle
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_state = S_PLAY;
        expect_now("start_to_play");
        repeat (3) step();
        expect_now("idle_no_change");

        // single drop with intermediate timing
        press(1'b0, 1'b0, 1'b1, 1'b0);
        m_state = S_DROP;
        expect_now("drop_enter");
        step();
        m_board[3] = 1'b1;
        height[3]  = 1;
        m_state    = S_CHKH;
        expect_now("drop_row0_visible");
        repeat (4) step();
        m_state  = S_PLAY;
        m_player = 1'b1;
        expect_now("drop_turn_toggle");

        // red vertical win
        reset_and_start();
        for (int i = 0; i < 7; i++)
            do_drop(vert_cols[i], (i == 6), 2'b01, $sformatf("vert_drop%0d", i));
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_reset();
        expect_now("vert_end_to_init");

        // black up-right diagonal win
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_state = S_PLAY;
        for (int i = 0; i < 12; i++)
            do_drop(diag_cols[i], (i == 11), 2'b10, $sformatf("diag_drop%0d", i));
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_reset();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_state = S_PLAY;

        // column full
        for (int i = 0; i < 6; i++)
            do_drop(2, 1'b0, 2'b00, $sformatf("fill_col2_%0d", i));
        press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("full_drop_ignored");
        repeat (6) step();
        expect_now("full_still_play");

        // selection movement
        move_to(3);
        repeat (5) press_sel(1'b1, 1'b0);
        expect_now("sel_left_saturate");
        repeat (10) press_sel(1'b0, 1'b1);
        expect_now("sel_right_saturate");
        move_to(4);
        press_sel(1'b1, 1'b1);
        expect_now("sel_both_no_change");
        press(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) step();
        m_board[4]  = 1'b1;
        m_colors[4] = m_player;
        height[4]++;
        m_player = ~m_player;
        expect_now("drop_with_right_same_col");

        // reset in the middle of a drop scan (scan_row 3)
        reset_and_start();
        for (int i = 0; i < 3; i++)
            do_drop(0, 1'b0, 2'b00, $sformatf("stack_col0_%0d", i));
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        m_state = S_DROP;
        expect_now("drop_scan_row3");
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        m_reset();
        expect_now("reset_mid_drop");

        // draw: 42 drops, no four in a row
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_state = S_PLAY;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < draw_cnt[i]; j++) begin
                k++;
                do_drop(draw_col[i], (k == 42), 2'b00, $sformatf("draw_drop%0d", k));
            end
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        m_reset();
        expect_now("draw_end_to_init");

        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/connect4_game_ctrl.md
Name: connect4_game_ctrl

Overview:
Game controller for Connect-4. It owns the board and colour state and the selected column, turn, winner and phase flags that drive the VGA display block. It sequences the start → play → end phases, drops chips into columns with a row-by-row scan, and checks the four win directions sequentially after every drop. It sits between the debounced button pulses and the display.

Parameters:
START_COL, 3, column index loaded into selected_col at reset and at the start of every new game (0..6).
FIRST_PLAYER, 0, player value at game start (0 = red, 1 = black).

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
btn_left  input  1  single-cycle pulse (debounced upstream); move selection left.
btn_right  input  1  single-cycle pulse; move selection right.
btn_drop  input  1  single-cycle pulse; drop a chip in selected_col.
btn_start  input  1  single-cycle pulse; start a game, or return to start after a game ends.
board  output  42  occupancy; bit 7*row+col; row 0 = bottom, col 0 = left.
colors  output  42  chip colour per cell, same indexing; 1 = black, 0 = red; meaningful only where board = 1.
selected_col  output  3  column of the hovering chip, 0..6.
player  output  1  current turn; 1 = black, 0 = red.
game_over  output  1  high while in END.
winner  output  2  00 = draw, 01 = red, 10 = black; valid while game_over = 1.
start_state  output  1  high while in INIT.
end_state  output  1  high while in END.

Behaviour:
- All outputs are registered.
- Reset values (applied on any cycle with Reset high, including mid-DROP or mid-CHECK):
  - board = 0, colors = 0
  - selected_col = START_COL, player = FIRST_PLAYER
  - winner = 00, game_over = 0, end_state = 0
  - start_state = 1, state = INIT, move_cnt = 0
- States: INIT, PLAY, DROP, CHK_H, CHK_V, CHK_D1, CHK_D2, END.
- INIT:
  - btn_start → PLAY next cycle, with start_state = 0.
  - All other buttons are ignored.
- PLAY, input priority:
  1. btn_drop has priority. If board[35+selected_col] = 1 (column full), the press is ignored and the state stays PLAY. Otherwise go to DROP with scan_row = 0; left/right in the same cycle are ignored.
  2. If btn_left and btn_right are both high, there is no change.
  3. btn_left: selected_col decrements, saturating at 0.
  4. btn_right: selected_col increments, saturating at 6.
- DROP (one row per cycle):
  - If board[7*scan_row+selected_col] = 0: set that board bit and set the colors bit = player; latch last_row = scan_row and last_col = selected_col; increment move_cnt; go to CHK_H.
  - Otherwise scan_row++.
  - A chip landing in row r is visible r+2 cycles after the drop cycle.
- CHK_H / CHK_V / CHK_D1 (up-right) / CHK_D2 (up-left), one cycle each:
  - Count same-colour occupied cells contiguous with (last_row, last_col), up to 3 each side in that direction.
  - Clip at board edges; no wrap between rows.
  - Total ≥ 4 → win_flag set.
  - Buttons are ignored during CHK states.
- After CHK_D2:
  - win_flag → END, winner = player ? 10 : 01.
  - Else move_cnt = 42 → END, winner = 00.
  - Else toggle player → PLAY; selected_col is retained.
- Timing: PLAY resumes r+6 cycles after an accepted drop into row r.
- END:
  - game_over = 1, end_state = 1; the board is held for display.
  - btn_start → INIT next cycle, with board = 0, colors = 0, player = FIRST_PLAYER, selected_col = START_COL, winner = 00, move_cnt = 0.
- move_cnt is 6 bits and never exceeds 42.

Test Plan:
- Reset, then btn_start pulse → next cycle start_state = 0, selected_col = 3, player = 0; no further output change without more stimulus.
- In PLAY, btn_drop at col 3 on an empty board → board[3] = 1 and colors[3] = 0 two cycles later; player = 1 six cycles after the drop.
- Red vertical win. Drops alternate red col 0, black col 1 three times, then red col 0 again. Required result: END with winner = 01, game_over = 1, board bits 0/7/14/21 = 1 with colors = 0, and bits 1/8/15 with colors = 1. Diagonal variant: black up-right four in a row → winner = 10.
- Column full:
  - Six drops into col 2 → board bits 2, 9, 16, 23, 30, 37 set.
  - A seventh drop leaves board/colors/player unchanged and the state stays PLAY.
- Selection movement, from col 3:
  - 5× btn_left → selected_col = 0.
  - 10× btn_right → 6.
  - btn_left and btn_right in the same cycle → unchanged.
  - btn_drop with btn_right in the same cycle → drop lands in the original column.
- Reset asserted during DROP at scan_row 3 → next cycle all reset values, including board = 0. Draw fill (42 drops, no four-in-a-row) → winner = 00, end_state = 1; btn_start → INIT with board cleared.
